// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI encodings, widths and engine state types for the SRAM-backed AXI3 responder.
package axi_sram_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_STRB_W = 8;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // Encodings are ordered by severity, so the numeric max is the worst response.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_sram_slave_addr_gen.sv
// Beat address generator for FIXED/INCR/WRAP bursts; flags oversize beats and illegal WRAP lengths.
module axi_burst_addr_gen
  import axi_sram_slave_pkg::*;
(
  input  logic [31:0] start_addr,
  input  logic [3:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  input  logic [3:0]  beat,
  output logic [31:0] beat_addr,
  output logic        illegal
);

  logic [1:0]  sz;
  logic [31:0] aligned;
  logic [31:0] step;
  logic [31:0] container;
  logic        wrap_len_ok;

  always_comb begin
    sz          = (size > 3'd3) ? 2'd3 : size[1:0];
    aligned     = start_addr & ~((32'd1 << sz) - 32'd1);
    step        = {28'd0, beat} << sz;
    container   = ({28'd0, len} + 32'd1) << sz;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    illegal     = (size > 3'd3) || ((burst == BURST_WRAP) && !wrap_len_ok);
    beat_addr   = aligned + step;
    case (burst)
      BURST_FIXED: beat_addr = start_addr;
      // An illegal WRAP length degrades to INCR stepping rather than an undefined container.
      BURST_WRAP:  if (wrap_len_ok)
                     beat_addr = (aligned & ~(container - 32'd1)) |
                                 ((aligned + step) & (container - 32'd1));
      default:     beat_addr = aligned + step;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a byte-addressed on-chip SRAM; independent single-outstanding read/write engines.
// Optional decode/protocol error reporting enabled by defining AXI_SRAM_SLV_ERR_EN.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_AW    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_W-1:0]       arid,
  input  logic [31:0]           araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic [1:0]            arlock,
  input  logic [3:0]            arcache,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_W-1:0]       rid,
  output logic [AXI_DATA_W-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ID_W-1:0]       awid,
  input  logic [31:0]           awaddr,
  input  logic [3:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic [1:0]            awlock,
  input  logic [3:0]            awcache,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_W-1:0]       wid,
  input  logic [AXI_DATA_W-1:0] wdata,
  input  logic [AXI_STRB_W-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int unsigned WORDS = 2 ** (MEM_AW - 3);

  logic [AXI_DATA_W-1:0] mem [WORDS];

  r_state_e r_state_q, r_state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [3:0]  ar_len_q, ar_len_d, r_beat_q, r_beat_d;
  logic [2:0]  ar_size_q, ar_size_d;
  logic [1:0]  ar_burst_q, ar_burst_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;

  w_state_e w_state_q, w_state_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [3:0]  aw_len_q, aw_len_d, w_beat_q, w_beat_d;
  logic [2:0]  aw_size_q, aw_size_d;
  logic [1:0]  aw_burst_q, aw_burst_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;

  logic r_idle;
  logic [31:0] rg_addr, r_addr, w_addr;
  logic [3:0]  rg_len, rg_beat;
  logic [2:0]  rg_size;
  logic [1:0]  rg_burst;
  logic        r_illegal, w_illegal, r_dec, w_dec, mem_we;
  logic [MEM_AW-4:0] r_widx, w_widx;
  logic [1:0]  r_beat_resp, w_beat_resp;

  // In idle the read generator looks at the live AR channel so beat 0 loads on the handshake edge.
  assign r_idle   = (r_state_q == R_IDLE);
  assign rg_addr  = r_idle ? araddr  : ar_addr_q;
  assign rg_len   = r_idle ? arlen   : ar_len_q;
  assign rg_size  = r_idle ? arsize  : ar_size_q;
  assign rg_burst = r_idle ? arburst : ar_burst_q;
  assign rg_beat  = r_idle ? 4'd0    : r_beat_q + 4'd1;

  axi_burst_addr_gen u_rd_gen (
    .start_addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
    .beat(rg_beat), .beat_addr(r_addr), .illegal(r_illegal)
  );

  axi_burst_addr_gen u_wr_gen (
    .start_addr(aw_addr_q), .len(aw_len_q), .size(aw_size_q), .burst(aw_burst_q),
    .beat(w_beat_q), .beat_addr(w_addr), .illegal(w_illegal)
  );

`ifdef AXI_SRAM_SLV_ERR_EN
  logic [31:0] r_off, w_off;
  logic        unused_sig;
  assign r_off  = r_addr - BASE_ADDR;
  assign w_off  = w_addr - BASE_ADDR;
  assign r_dec  = (r_off >> MEM_AW) != '0;
  assign w_dec  = (w_off >> MEM_AW) != '0;
  assign r_widx = r_off[MEM_AW-1:3];
  assign w_widx = w_off[MEM_AW-1:3];
  assign r_beat_resp = r_dec ? RESP_DECERR : (r_illegal ? RESP_SLVERR : RESP_OKAY);
  assign w_beat_resp = w_dec ? RESP_DECERR :
                       ((w_illegal || (wid != bid_q) || (wlast != (w_beat_q == aw_len_q)))
                        ? RESP_SLVERR : RESP_OKAY);
  assign unused_sig  = ^{r_off[2:0], w_off[2:0], arlock, arcache, arprot, awlock, awcache, awprot};
`else
  logic unused_sig;
  assign r_dec  = 1'b0;
  assign w_dec  = 1'b0;
  assign r_widx = r_addr[MEM_AW-1:3];
  assign w_widx = w_addr[MEM_AW-1:3];
  assign r_beat_resp = RESP_OKAY;
  assign w_beat_resp = RESP_OKAY;
  assign unused_sig  = ^{r_addr[31:MEM_AW], r_addr[2:0], w_addr[31:MEM_AW], w_addr[2:0],
                         r_illegal, w_illegal, wid, wlast, BASE_ADDR,
                         arlock, arcache, arprot, awlock, awcache, awprot};
`endif

  always_comb begin
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_beat_d   = r_beat_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    case (r_state_q)
      R_IDLE: if (arvalid) begin
        r_state_d  = R_DATA;
        ar_addr_d  = araddr;
        ar_len_d   = arlen;
        ar_size_d  = arsize;
        ar_burst_d = arburst;
        r_beat_d   = 4'd0;
        rid_d      = arid;
      end
      default: if (rready) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
          rlast_d   = 1'b0;
        end else begin
          r_beat_d  = r_beat_q + 4'd1;
        end
      end
    endcase
    if ((r_idle && arvalid) || (!r_idle && rready && !rlast_q)) begin
      rdata_d = r_dec ? '0 : mem[r_widx];
      rresp_d = r_beat_resp;
      rlast_d = (rg_beat == rg_len);
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_beat_d   = w_beat_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    case (w_state_q)
      W_IDLE: if (awvalid) begin
        w_state_d  = W_DATA;
        aw_addr_d  = awaddr;
        aw_len_d   = awlen;
        aw_size_d  = awsize;
        aw_burst_d = awburst;
        w_beat_d   = 4'd0;
        bid_d      = awid;
        bresp_d    = RESP_OKAY;
      end
      W_DATA: if (wvalid) begin
        mem_we  = !w_dec;
        bresp_d = resp_max(bresp_q, w_beat_resp);
        if (w_beat_q == aw_len_q) w_state_d = W_RESP;
        else                      w_beat_d  = w_beat_q + 4'd1;
      end
      default: if (bready) w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;   ar_addr_q <= '0; ar_len_q <= '0; ar_size_q <= '0;
      ar_burst_q <= '0;      r_beat_q <= '0;  rid_q <= '0;    rdata_q <= '0;
      rresp_q <= '0;         rlast_q <= 1'b0;
      w_state_q <= W_IDLE;   aw_addr_q <= '0; aw_len_q <= '0; aw_size_q <= '0;
      aw_burst_q <= '0;      w_beat_q <= '0;  bid_q <= '0;    bresp_q <= '0;
    end else begin
      r_state_q <= r_state_d; ar_addr_q <= ar_addr_d; ar_len_q <= ar_len_d; ar_size_q <= ar_size_d;
      ar_burst_q <= ar_burst_d; r_beat_q <= r_beat_d; rid_q <= rid_d;   rdata_q <= rdata_d;
      rresp_q <= rresp_d;     rlast_q <= rlast_d;
      w_state_q <= w_state_d; aw_addr_q <= aw_addr_d; aw_len_q <= aw_len_d; aw_size_q <= aw_size_d;
      aw_burst_q <= aw_burst_d; w_beat_q <= w_beat_d; bid_q <= bid_d;   bresp_q <= bresp_d;
    end
  end

  // SRAM contents survive reset; the read path above samples the pre-write word on a shared edge.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < AXI_STRB_W; i++) begin
        if (wstrb[i]) mem[w_widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign arready = r_idle;
  assign rvalid  = (r_state_q == R_DATA);
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = bid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed bursts push expected R/B responses, monitors pop and compare.
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arlen, awlen, arcache, awcache;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] rdata, wdata;
  logic [7:0]  wstrb;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t r_q[$];
  b_exp_t b_q[$];
  logic [63:0] wbuf [16];
  int errors = 0;
  int checks = 0;

  axi_sram_slave #(.ID_W(4), .MEM_AW(16), .BASE_ADDR(32'h1c000000)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_r(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    r_q.push_back('{id: id, data: d, resp: resp, last: last});
  endtask

  // Monitors: sample half a cycle away from the active edge.
  logic        stalled = 1'b0;
  logic [70:0] held;
  always @(negedge aclk) begin
    r_exp_t er;
    b_exp_t eb;
    if (aresetn && stalled) begin
      checks++;
      if (!rvalid || {rid, rdata, rresp, rlast} !== held) begin
        errors++;
        $display("FAIL r_stall_hold: got v=%b %h expected v=1 %h", rvalid, {rid, rdata, rresp, rlast}, held);
      end
    end
    stalled = aresetn && rvalid && !rready;
    held    = {rid, rdata, rresp, rlast};
    if (aresetn && rvalid && rready) begin
      checks++;
      if (r_q.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: got id=%h data=%h resp=%b last=%b expected no beat", rid, rdata, rresp, rlast);
      end else begin
        er = r_q.pop_front();
        if ({rid, rdata, rresp, rlast} !== er) begin
          errors++;
          $display("FAIL r_beat: got id=%h data=%h resp=%b last=%b expected id=%h data=%h resp=%b last=%b",
                   rid, rdata, rresp, rlast, er.id, er.data, er.resp, er.last);
        end
      end
    end
    if (aresetn && bvalid && bready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got id=%h resp=%b expected no response", bid, bresp);
      end else begin
        eb = b_q.pop_front();
        if ({bid, bresp} !== eb) begin
          errors++;
          $display("FAIL b_resp: got id=%h resp=%b expected id=%h resp=%b", bid, bresp, eb.id, eb.resp);
        end
      end
    end
  end

  // All drivers start and end at posedge+1.
  task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 200) begin @(negedge aclk); n++; end
    if (!arready) chk("ar_timeout", 64'(arready), 64'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    chk("rvalid_latency", 64'(rvalid), 64'd1);
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < 200) begin @(negedge aclk); n++; end
    if (!awready) chk("aw_timeout", 64'(awready), 64'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [3:0] id, input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    wid = id; wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    @(negedge aclk);
    while (!wready && n < 200) begin @(negedge aclk); n++; end
    if (!wready) chk("w_timeout", 64'(wready), 64'd1);
    @(posedge aclk); #1;
    wvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                             input logic [7:0] s);
    b_q.push_back('{id: id, resp: 2'b00});
    aw_send(id, a, len, 3'd3, 2'b01);
    for (int i = 0; i <= int'(len); i++) w_send(id, wbuf[i], s, i == int'(len));
  endtask

  task automatic drain();
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0 || rvalid || bvalid) && n < 300) begin
      @(posedge aclk); #1; n++;
    end
    if (n >= 300) chk("drain_timeout", 64'(r_q.size() + b_q.size()), 64'd0);
  endtask

  initial begin
    aresetn = 1'b0; rready = 1'b1; bready = 1'b1;
    arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arlock = '0; arcache = '0; arprot = '0;
    awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awlock = '0; awcache = '0; awprot = '0;
    wvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_rvalid", 64'(rvalid), 64'd0);   chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rdata", rdata, 64'd0);          chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);     chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);         chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);   chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_awready", 64'(awready), 64'd1);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // INCR 4-beat write then read back
    wbuf[0] = 64'h1111111111111111; wbuf[1] = 64'h2222222222222222;
    wbuf[2] = 64'h3333333333333333; wbuf[3] = 64'h4444444444444444;
    write_burst(4'h5, 32'h1c000100, 4'd3, 8'hFF);
    drain();
    push_r(4'h3, 64'h1111111111111111, 2'b00, 1'b0);
    push_r(4'h3, 64'h2222222222222222, 2'b00, 1'b0);
    push_r(4'h3, 64'h3333333333333333, 2'b00, 1'b0);
    push_r(4'h3, 64'h4444444444444444, 2'b00, 1'b1);
    ar_send(4'h3, 32'h1c000100, 4'd3, 3'd3, 2'b01);
    drain();

    // WRAP from 0x118: 0x118, 0x100, 0x108, 0x110
    push_r(4'h7, 64'h4444444444444444, 2'b00, 1'b0);
    push_r(4'h7, 64'h1111111111111111, 2'b00, 1'b0);
    push_r(4'h7, 64'h2222222222222222, 2'b00, 1'b0);
    push_r(4'h7, 64'h3333333333333333, 2'b00, 1'b1);
    ar_send(4'h7, 32'h1c000118, 4'd3, 3'd3, 2'b10);
    drain();

    // FIXED 2-beat read repeats one word
    push_r(4'h1, 64'h2222222222222222, 2'b00, 1'b0);
    push_r(4'h1, 64'h2222222222222222, 2'b00, 1'b1);
    ar_send(4'h1, 32'h1c000108, 4'd1, 3'd3, 2'b00);
    drain();

    // 8-beat read with rready toggling every cycle
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0DE000000000000 | 64'(i);
    write_burst(4'h2, 32'h1c000200, 4'd7, 8'hFF);
    drain();
    for (int i = 0; i < 8; i++) push_r(4'h9, 64'hC0DE000000000000 | 64'(i), 2'b00, i == 7);
    rready = 1'b0;
    ar_send(4'h9, 32'h1c000200, 4'd7, 3'd3, 2'b01);
    repeat (40) begin @(posedge aclk); #1; rready = ~rready; end
    rready = 1'b1;
    drain();

    // Partial strobe over an all-ones word
    wbuf[0] = 64'hFFFFFFFFFFFFFFFF;
    write_burst(4'h4, 32'h1c000300, 4'd0, 8'hFF);
    wbuf[0] = 64'hAAAAAAAABBBBBBBB;
    write_burst(4'h4, 32'h1c000300, 4'd0, 8'h0F);
    wbuf[0] = 64'h5555555555555555;
    write_burst(4'h4, 32'h1c000308, 4'd0, 8'h00);
    drain();
    push_r(4'h4, 64'hFFFFFFFFBBBBBBBB, 2'b00, 1'b1);
    ar_send(4'h4, 32'h1c000300, 4'd0, 3'd3, 2'b01);
    drain();

    // Write and read of the same word on the same edge: read sees the old value
    b_q.push_back('{id: 4'h2, resp: 2'b00});
    push_r(4'h6, 64'hFFFFFFFFBBBBBBBB, 2'b00, 1'b1);
    aw_send(4'h2, 32'h1c000300, 4'd0, 3'd3, 2'b01);
    wid = 4'h2; wdata = 64'h123456789ABCDEF0; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'h6; araddr = 32'h1c000300; arlen = 4'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    @(negedge aclk);
    chk("simul_ready", 64'({wready, arready}), 64'd3);
    @(posedge aclk); #1;
    wvalid = 1'b0; arvalid = 1'b0;
    drain();
    push_r(4'h6, 64'h123456789ABCDEF0, 2'b00, 1'b1);
    ar_send(4'h6, 32'h1c000300, 4'd0, 3'd3, 2'b01);
    drain();

    // Out-of-window read
    wbuf[0] = 64'hD0D0D0D0D0D0D0D0; wbuf[1] = 64'hD1D1D1D1D1D1D1D1;
    write_burst(4'h8, 32'h1c000000, 4'd1, 8'hFF);
    drain();
`ifdef AXI_SRAM_SLV_ERR_EN
    push_r(4'hA, 64'd0, 2'b11, 1'b0);
    push_r(4'hA, 64'd0, 2'b11, 1'b1);
`else
    push_r(4'hA, 64'hD0D0D0D0D0D0D0D0, 2'b00, 1'b0);
    push_r(4'hA, 64'hD1D1D1D1D1D1D1D1, 2'b00, 1'b1);
`endif
    ar_send(4'hA, 32'h00000000, 4'd1, 3'd3, 2'b01);
    drain();

    // Reset in the middle of a stalled 16-beat read
    rready = 1'b0;
    ar_send(4'hB, 32'h1c000100, 4'd15, 3'd3, 2'b01);
    @(posedge aclk); #3;
    aresetn = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_rlast", 64'(rlast), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rready  = 1'b1;
    @(negedge aclk);
    chk("postrst_arready", 64'(arready), 64'd1);
    @(posedge aclk); #1;
    push_r(4'hC, 64'h1111111111111111, 2'b00, 1'b0);
    push_r(4'hC, 64'h2222222222222222, 2'b00, 1'b1);
    ar_send(4'hC, 32'h1c000100, 4'd1, 3'd3, 2'b01);
    drain();
    push_r(4'hD, 64'h123456789ABCDEF0, 2'b00, 1'b1);
    ar_send(4'hD, 32'h1c000300, 4'd0, 3'd3, 2'b01);
    drain();

    chk("leftover_expectations", 64'(r_q.size() + b_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
